// File: rtl/stereo_router.sv
// -----------------------------------------------------------------------------
// stereo_router
//
// Splits a mono sample stream into a left and a right channel. Each channel
// has its own gain. The gain ramps toward a target that is set by the
// listening mode. This avoids clicks when a channel is switched on or off.
//
// Pipeline (one sample may be accepted every cycle):
//   edge 0 : the strobed sample and the freshly stepped gains are captured
//   cycle 1: sample * gain is formed combinationally (WIDTH+6 bits)
//   edge 1 : product >>> 4 is registered into the outputs, and out_valid rises
//
// As a result, out_valid is high in the second cycle after the strobe cycle.
//
// Handshake: there is no back-pressure. new_sample is a one-cycle strobe that
// qualifies sample_in. out_valid is a one-cycle strobe that marks new values on
// left_out/right_out. The outputs hold their values between strobes.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   aural_state  listening mode: 11 both, 10 left only, 01 right only, 00 mute
//   new_sample   input strobe qualifying sample_in
//   sample_in    signed mono sample
//   left_out     signed left sample (registered)
//   right_out    signed right sample (registered)
//   out_valid    output strobe
//   ramping      high while either gain differs from its target
// -----------------------------------------------------------------------------
module stereo_router #(
    parameter int WIDTH     = 16,
    parameter int RAMP_STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       aural_state,
    input  logic             new_sample,
    input  logic [WIDTH-1:0] sample_in,
    output logic [WIDTH-1:0] left_out,
    output logic [WIDTH-1:0] right_out,
    output logic             out_valid,
    output logic             ramping
);

    localparam logic [4:0] C_UNITY = 5'd16;
    localparam logic [4:0] C_STEP  = 5'(RAMP_STEP);

    logic [1:0]       r_aural_q;
    logic [4:0]       r_gain_l;
    logic [4:0]       r_gain_r;
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_sample;
    logic [4:0]       r_s1_gain_l;
    logic [4:0]       r_s1_gain_r;
    logic [WIDTH-1:0] r_left;
    logic [WIDTH-1:0] r_right;
    logic             r_out_valid;

    logic [4:0]       w_tgt_l;
    logic [4:0]       w_tgt_r;
    logic [4:0]       w_gain_l_nxt;
    logic [4:0]       w_gain_r_nxt;
    logic [WIDTH+5:0] w_samp_ext;
    logic [WIDTH+5:0] w_gain_l_ext;
    logic [WIDTH+5:0] w_gain_r_ext;
    logic [WIDTH+5:0] w_prod_l;
    logic [WIDTH+5:0] w_prod_r;
    logic             w_unused_bits;

    // Move one step toward the target. When the remaining distance is less
    // than a step, snap onto the target so the gain never overshoots.
    function automatic logic [4:0] f_ramp(input logic [4:0] gain, input logic [4:0] tgt);
        logic [4:0] res;
        res = gain;
        if (gain < tgt) begin
            res = ((tgt - gain) < C_STEP) ? tgt : gain + C_STEP;
        end else if (gain > tgt) begin
            res = ((gain - tgt) < C_STEP) ? tgt : gain - C_STEP;
        end
        return res;
    endfunction

    assign w_tgt_l      = r_aural_q[1] ? C_UNITY : 5'd0;
    assign w_tgt_r      = r_aural_q[0] ? C_UNITY : 5'd0;
    assign w_gain_l_nxt = f_ramp(r_gain_l, w_tgt_l);
    assign w_gain_r_nxt = f_ramp(r_gain_r, w_tgt_r);
    assign ramping      = (r_gain_l != w_tgt_l) || (r_gain_r != w_tgt_r);

    // The gain is non-negative, so it is zero-extended. The sample is
    // sign-extended. The product of these two at WIDTH+6 bits is the exact
    // signed product, because |sample| * 16 always fits in WIDTH+5 bits.
    assign w_samp_ext   = {{6{r_s1_sample[WIDTH-1]}}, r_s1_sample};
    assign w_gain_l_ext = {{(WIDTH+1){1'b0}}, r_s1_gain_l};
    assign w_gain_r_ext = {{(WIDTH+1){1'b0}}, r_s1_gain_r};
    assign w_prod_l     = w_samp_ext * w_gain_l_ext;
    assign w_prod_r     = w_samp_ext * w_gain_r_ext;

    // Taking bits [WIDTH+3:4] is an arithmetic shift right by 4 (floor) that
    // is then truncated to WIDTH bits. The discarded bits are collected here.
    assign w_unused_bits = ^{w_prod_l[3:0], w_prod_l[WIDTH+5:WIDTH+4],
                             w_prod_r[3:0], w_prod_r[WIDTH+5:WIDTH+4]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_aural_q   <= 2'b11;
            r_gain_l    <= C_UNITY;
            r_gain_r    <= C_UNITY;
            r_s1_valid  <= 1'b0;
            r_s1_sample <= '0;
            r_s1_gain_l <= C_UNITY;
            r_s1_gain_r <= C_UNITY;
            r_left      <= '0;
            r_right     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_aural_q   <= aural_state;
            r_s1_valid  <= new_sample;
            r_out_valid <= r_s1_valid;
            // Gains only move on accepted samples. A mode change between
            // strobes waits for the next sample to take effect.
            if (new_sample) begin
                r_gain_l    <= w_gain_l_nxt;
                r_gain_r    <= w_gain_r_nxt;
                r_s1_sample <= sample_in;
                r_s1_gain_l <= w_gain_l_nxt;
                r_s1_gain_r <= w_gain_r_nxt;
            end
            if (r_s1_valid) begin
                r_left  <= w_prod_l[WIDTH+3:4];
                r_right <= w_prod_r[WIDTH+3:4];
            end
        end
    end

    assign left_out  = r_left;
    assign right_out = r_right;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_stereo_router.sv
module tb_stereo_router;

    logic        clk;
    logic        rst;
    logic [1:0]  aural_state;
    logic        new_sample;
    logic [15:0] sample_in;
    logic [15:0] left_out;
    logic [15:0] right_out;
    logic        out_valid;
    logic        ramping;

    int n_tests = 0;
    int n_fail  = 0;

    stereo_router #(.WIDTH(16), .RAMP_STEP(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .aural_state (aural_state),
        .new_sample  (new_sample),
        .sample_in   (sample_in),
        .left_out    (left_out),
        .right_out   (right_out),
        .out_valid   (out_valid),
        .ramping     (ramping)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Checker
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_left",    32'(left_out),  32'h0);
        check("rst_right",   32'(right_out), 32'h0);
        check("rst_valid",   32'(out_valid), 32'h0);
        check("rst_ramping", 32'(ramping),   32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_aural(input logic [1:0] v);
        @(negedge clk);
        aural_state = v;
        @(negedge clk);
    endtask

    // One strobe. Outputs are expected two cycles after the strobe cycle.
    task automatic send_check(input string tag, input logic [15:0] s,
                              input logic [15:0] exp_l, input logic [15:0] exp_r);
        @(negedge clk);
        new_sample = 1'b1;
        sample_in  = s;
        @(negedge clk);
        new_sample = 1'b0;
        check({tag, "_early"}, 32'(out_valid), 32'h0);
        @(negedge clk);
        check({tag, "_valid"}, 32'(out_valid), 32'h1);
        check({tag, "_left"},  32'(left_out),  32'(exp_l));
        check({tag, "_right"}, 32'(right_out), 32'(exp_r));
    endtask

    logic [15:0] vals [10];

    initial begin
        rst         = 1'b0;
        aural_state = 2'b11;
        new_sample  = 1'b0;
        sample_in   = '0;
        #2;
        rst = 1'b1;
        #1;
        check("init_left",    32'(left_out),  32'h0);
        check("init_right",   32'(right_out), 32'h0);
        check("init_valid",   32'(out_valid), 32'h0);
        check("init_ramping", 32'(ramping),   32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Unity passthrough on both channels
        send_check("unity", 16'h1234, 16'h1234, 16'h1234);
        check("unity_ramping", 32'(ramping), 32'h0);

        // Left only: the right channel ramps down by 1/16 per sample
        set_aural(2'b10);
        check("l_only_ramp_start", 32'(ramping), 32'h1);
        for (int i = 1; i <= 16; i++) begin
            send_check($sformatf("l_only_%0d", i), 16'h1000, 16'h1000, 16'((16 - i) << 8));
            check($sformatf("l_only_ramping_%0d", i), 32'(ramping), 32'((i < 16) ? 1 : 0));
        end
        @(negedge clk);
        @(negedge clk);
        check("hold_valid", 32'(out_valid), 32'h0);
        check("hold_left",  32'(left_out),  32'h1000);
        check("hold_right", 32'(right_out), 32'h0000);

        // Gain 15: the result is rounded toward minus infinity
        do_reset();
        set_aural(2'b10);
        send_check("g15_neg_full", 16'h8000, 16'h8000, 16'h8800);
        do_reset();
        set_aural(2'b10);
        send_check("g15_minus1", 16'hFFFF, 16'hFFFF, 16'hFFFF);

        // Mute halfway, then reverse the ramp back to unity
        do_reset();
        set_aural(2'b00);
        for (int i = 1; i <= 8; i++)
            send_check($sformatf("mute_%0d", i), 16'h0100, 16'((16 - i) << 4), 16'((16 - i) << 4));
        set_aural(2'b11);
        check("reverse_ramping", 32'(ramping), 32'h1);
        for (int i = 1; i <= 8; i++)
            send_check($sformatf("unmute_%0d", i), 16'h0100, 16'((8 + i) << 4), 16'((8 + i) << 4));
        check("unmute_ramping", 32'(ramping), 32'h0);
        send_check("unmute_unity", 16'hA5A5, 16'hA5A5, 16'hA5A5);

        // Back-to-back strobes on 10 consecutive cycles
        for (int i = 0; i < 10; i++) vals[i] = 16'(i * 16'h1357 + 16'h8001);
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            if (k >= 2 && k < 12) begin
                check($sformatf("b2b_valid_%0d", k), 32'(out_valid), 32'h1);
                check($sformatf("b2b_left_%0d", k),  32'(left_out),  32'(vals[k-2]));
                check($sformatf("b2b_right_%0d", k), 32'(right_out), 32'(vals[k-2]));
            end else begin
                check($sformatf("b2b_idle_%0d", k), 32'(out_valid), 32'h0);
            end
            new_sample = (k < 10);
            sample_in  = (k < 10) ? vals[k] : 16'h0;
        end

        // Reset one cycle after a strobe discards the sample in flight
        set_aural(2'b00);
        @(negedge clk);
        new_sample = 1'b1;
        sample_in  = 16'h7777;
        @(negedge clk);
        new_sample = 1'b0;
        rst        = 1'b1;
        #1;
        check("midrst_valid0", 32'(out_valid), 32'h0);
        check("midrst_left",   32'(left_out),  32'h0);
        aural_state = 2'b11;
        @(negedge clk);
        check("midrst_valid1", 32'(out_valid), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_valid2",  32'(out_valid), 32'h0);
        check("midrst_ramping", 32'(ramping),   32'h0);
        send_check("post_rst", 16'h4321, 16'h4321, 16'h4321);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stereo_router.md
STEREO_ROUTER -- requirements
Module: stereo_router

Interface
REQ-001 Parameter: WIDTH, 16, signed audio sample width in bits.
REQ-002 Parameter: RAMP_STEP, 1, gain change per accepted sample; legal range 1..16.
REQ-003 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous and active-high.
REQ-005 Port: aural_state  input  2  listening-mode code: 11 both channels, 10 left only, 01 right only, 00 mute both.
REQ-006 Port: new_sample  input  1  one-cycle strobe; sample_in is valid in this cycle.
REQ-007 Port: sample_in  input  WIDTH  signed two's-complement mono sample.
REQ-008 Port: left_out  output  WIDTH  signed left-channel sample, registered.
REQ-009 Port: right_out  output  WIDTH  signed right-channel sample, registered.
REQ-010 Port: out_valid  output  1  one-cycle strobe; left_out/right_out are new in this cycle.
REQ-011 Port: ramping  output  1  high while either channel gain differs from its target.

Function
REQ-012 aural_state SHALL be registered into aural_q every cycle; only aural_q drives targets.
REQ-013 Per-channel gains gain_l and gain_r SHALL be 5-bit unsigned, range 0..16, where 16 means unity.
REQ-014 Targets: tgt_l = aural_q[1] ? 16 : 0; tgt_r = aural_q[0] ? 16 : 0.
REQ-015 Gains SHALL change only in a cycle with new_sample=1; each gain moves RAMP_STEP toward its target.
REQ-016 When |target-gain| < RAMP_STEP, the gain SHALL be set equal to the target, with no overshoot.
REQ-017 A gain SHALL never leave the range 0..16.
REQ-018 Stage 1: in a cycle with new_sample=1, the block SHALL capture sample_in and the updated gains.
REQ-019 Stage 2, the next cycle: products = sample * gain, signed, WIDTH+6 bits, no overflow possible.
REQ-020 Stage 3: outputs = product arithmetic-shifted right by 4 and truncated toward minus infinity to WIDTH bits.
REQ-021 The gain=16 case SHALL be an exact passthrough; gain=0 SHALL output 0.
REQ-022 out_valid SHALL assert exactly 2 cycles after the new_sample cycle, for 1 cycle.
REQ-023 left_out and right_out SHALL hold their values between out_valid pulses.
REQ-024 The pipeline SHALL accept new_sample every cycle; back-to-back strobes SHALL give back-to-back out_valid.
REQ-025 An aural_state change between strobes SHALL NOT alter any gain until the next new_sample.
REQ-026 A target reversal mid-ramp SHALL make the ramp continue from the current gain toward the new target.
REQ-027 ramping SHALL be combinational on (gain_l != tgt_l) || (gain_r != tgt_r).

Reset
REQ-028 While rst=1, all of the following SHALL hold immediately, regardless of clk:
- aural_q = 11
- gain_l = gain_r = 16
- pipeline valid flags = 0
- left_out = right_out = 0
- out_valid = 0
- ramping = 0
REQ-029 Reset mid-pipeline SHALL discard in-flight samples; no out_valid SHALL be produced for a strobe accepted before reset.
REQ-030 After rst deasserts, the first new_sample SHALL be processed normally, with out_valid 2 cycles later.

Verification
REQ-031 After reset, with aural_state=11: sample_in=0x1234 with one strobe -> 2 cycles later out_valid=1, left_out=right_out=0x1234, ramping=0.
REQ-032 With aural_state=10 and 16 strobes of 0x1000:
- right_out = 0x0F00, 0x0E00, ..., 0x0000
- left_out = 0x1000 throughout
- ramping falls after the 16th strobe
REQ-033 With gain_r=15: sample 0x8000 -> right_out=0x8800; sample 0xFFFF -> right_out=0xFFFF (floor rounding).
REQ-034 aural_state=00, 8 strobes (gains reach 8), then aural_state=11, 8 more strobes -> gains return to 16, ramping=0, outputs equal input.
REQ-035 Strobes on 10 consecutive cycles -> out_valid high for 10 consecutive cycles starting 2 cycles later, each output matching its sample.
REQ-036 rst pulse one cycle after a strobe -> out_valid stays 0, gains read 16, and the next strobe yields a unity output at +2 cycles.
